// File: rtl/i2s_transmitter.sv
// I2S transmitter: lock-qualified start, valid/ready stereo intake and 64-BCLK frames
// of two 32-bit slots carrying MSB-first samples after the one-BCLK I2S delay.
module i2s_transmitter #(
    parameter int unsigned BCLK_DIV     = 20,
    parameter int unsigned LOCK_CYCLES  = 256,
    parameter int unsigned SAMPLE_WIDTH = 24
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    pll_locked,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [SAMPLE_WIDTH-1:0] s_left,
    input  logic [SAMPLE_WIDTH-1:0] s_right,
    output logic                    bclk,
    output logic                    lrclk,
    output logic                    sdata,
    output logic                    underrun,
    output logic                    running
);
    localparam int unsigned DIV_W  = $clog2(BCLK_DIV);
    localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(BCLK_DIV / 2);
    localparam logic [LOCK_W-1:0] LOCK_DONE = LOCK_W'(LOCK_CYCLES);

    typedef enum logic {WAIT_LOCK, RUN} state_t;

    state_t state, state_next;

    logic                    lock_meta, lock_sync;
    logic [LOCK_W-1:0]       lock_cnt, lock_cnt_next;
    logic [DIV_W-1:0]        div_cnt, div_cnt_next;
    logic [5:0]              bit_cnt, bit_cnt_next;
    logic [SAMPLE_WIDTH-1:0] hold_l, hold_r, hold_l_next, hold_r_next;
    logic [SAMPLE_WIDTH-1:0] frame_l, frame_r, frame_l_next, frame_r_next;
    logic                    hold_full, hold_full_next;
    logic                    bclk_next, lrclk_next, sdata_next;
    logic                    ready_next, underrun_next, running_next;
    logic                    advance, boundary, xfer;
    logic [31:0]             left_word, right_word;
    logic [63:0]             slot_vec;

    always_ff @(posedge refclk) begin
        if (rst) state <= WAIT_LOCK;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_LOCK: if (lock_sync && lock_cnt == LOCK_DONE) state_next = RUN;
            RUN:       if (!lock_sync) state_next = WAIT_LOCK;
        endcase
    end

    assign advance  = (state == RUN) && (state_next == RUN);
    assign boundary = advance && (bit_cnt == 6'd63) && (div_cnt == DIV_LAST);
    assign xfer     = s_valid && s_ready;

    // Everything not explicitly carried forward falls back to zero, which
    // covers both the WAIT_LOCK->RUN entry and the lock-loss flush.
    always_comb begin
        lock_cnt_next  = '0;
        div_cnt_next   = '0;
        bit_cnt_next   = '0;
        hold_l_next    = '0;
        hold_r_next    = '0;
        hold_full_next = 1'b0;
        frame_l_next   = '0;
        frame_r_next   = '0;
        underrun_next  = 1'b0;
        bclk_next      = 1'b0;
        lrclk_next     = 1'b0;
        sdata_next     = 1'b0;
        ready_next     = 1'b0;
        running_next   = 1'b0;

        if (state == WAIT_LOCK && lock_sync && state_next == WAIT_LOCK)
            lock_cnt_next = lock_cnt + 1'b1;

        if (advance) begin
            div_cnt_next   = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            bit_cnt_next   = (div_cnt == DIV_LAST) ? bit_cnt + 6'd1 : bit_cnt;
            hold_l_next    = hold_l;
            hold_r_next    = hold_r;
            hold_full_next = hold_full;
            frame_l_next   = frame_l;
            frame_r_next   = frame_r;
            if (boundary) begin
                frame_l_next   = hold_full ? hold_l : '0;
                frame_r_next   = hold_full ? hold_r : '0;
                underrun_next  = !hold_full;
                hold_full_next = 1'b0;
            end
            if (xfer) begin
                hold_l_next    = s_left;
                hold_r_next    = s_right;
                hold_full_next = 1'b1;
            end
        end

        // Slot k maps to slot_vec[63-k]; slot 0 and the word tails stay zero.
        left_word  = 32'(frame_l_next) << (32 - SAMPLE_WIDTH);
        right_word = 32'(frame_r_next) << (32 - SAMPLE_WIDTH);
        slot_vec   = {1'b0, left_word, 31'(right_word >> 1)};

        if (state_next == RUN) begin
            running_next = 1'b1;
            bclk_next    = (div_cnt_next >= DIV_HALF);
            lrclk_next   = bit_cnt_next[5];
            sdata_next   = slot_vec[~bit_cnt_next];
            ready_next   = !hold_full_next;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
            lock_cnt  <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            hold_l    <= '0;
            hold_r    <= '0;
            hold_full <= 1'b0;
            frame_l   <= '0;
            frame_r   <= '0;
            bclk      <= 1'b0;
            lrclk     <= 1'b0;
            sdata     <= 1'b0;
            s_ready   <= 1'b0;
            underrun  <= 1'b0;
            running   <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
            lock_cnt  <= lock_cnt_next;
            div_cnt   <= div_cnt_next;
            bit_cnt   <= bit_cnt_next;
            hold_l    <= hold_l_next;
            hold_r    <= hold_r_next;
            hold_full <= hold_full_next;
            frame_l   <= frame_l_next;
            frame_r   <= frame_r_next;
            bclk      <= bclk_next;
            lrclk     <= lrclk_next;
            sdata     <= sdata_next;
            s_ready   <= ready_next;
            underrun  <= underrun_next;
            running   <= running_next;
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: per-frame vector table plus hand-written
// sequences for lock qualification, lock loss and mid-transfer reset.
`timescale 1ns/1ps
module tb_i2s_transmitter;
    localparam int SW = 24;

    logic          refclk = 1'b0;
    logic          rst, pll_locked, s_valid;
    logic          s_ready, bclk, lrclk, sdata, underrun, running;
    logic [SW-1:0] s_left, s_right;

    int vectors     = 0;
    int miscompares = 0;

    always #5 refclk = ~refclk;

    i2s_transmitter #(.BCLK_DIV(20), .LOCK_CYCLES(256), .SAMPLE_WIDTH(SW)) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_left    (s_left),
        .s_right   (s_right),
        .bclk      (bclk),
        .lrclk     (lrclk),
        .sdata     (sdata),
        .underrun  (underrun),
        .running   (running)
    );

    // pre: offer the pair during the boundary cycle; send: offer it at slot 0;
    // keep: hold s_valid high and advance the data after each transfer.
    typedef struct {
        logic          pre;
        logic          send;
        logic          keep;
        logic [SW-1:0] l, r, el, er;
        logic          eur;
        int            exf;
    } frame_vec_t;

    frame_vec_t tbl [11];

    function automatic frame_vec_t mk(input logic pre, input logic send, input logic keep,
                                      input logic [SW-1:0] l, input logic [SW-1:0] r,
                                      input logic [SW-1:0] el, input logic [SW-1:0] er,
                                      input logic eur, input int exf);
        frame_vec_t v;
        v.pre = pre; v.send = send; v.keep = keep;
        v.l = l; v.r = r; v.el = el; v.er = er; v.eur = eur; v.exf = exf;
        return v;
    endfunction

    // Serial image of one frame, slot 0 in the MSB.
    function automatic logic [63:0] frame_word(input logic [SW-1:0] l, input logic [SW-1:0] r);
        return {1'b0, l, 8'h00, r, 7'h00};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic wait_running(output int n);
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (running === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Called on the first RUN cycle; consumes the rest of the all-zero first frame.
    task automatic first_frame(input string tag);
        int errs;
        errs = 0;
        check({tag, " first cycle"}, 64'({bclk, lrclk, sdata, s_ready, underrun, running}),
              64'(6'b000101));
        for (int c = 1; c < 1280; c++) begin
            tick();
            if (sdata !== 1'b0 || underrun !== 1'b0 || running !== 1'b1) errs++;
            if (bclk !== ((c % 20) >= 10) || lrclk !== ((c / 20) >= 32)) errs++;
        end
        check({tag, " first frame errs"}, 64'(errs), 64'(0));
    endtask

    task automatic run_frame(input frame_vec_t v, input string tag);
        logic [63:0] cap;
        logic [5:0]  idx;
        logic        pend, prev_sd;
        int          urc, ur0, xf, perr, phase, slot;
        cap = '0; pend = 1'b0; prev_sd = 1'b0;
        urc = 0; ur0 = 0; xf = 0; perr = 0;
        if (v.pre) begin
            s_left = v.l; s_right = v.r; s_valid = 1'b1;
        end
        for (int c = 0; c < 1280; c++) begin
            tick();
            phase = c % 20;
            slot  = c / 20;
            if (bclk !== (phase >= 10)) perr++;
            if (lrclk !== (slot >= 32)) perr++;
            if (running !== 1'b1) perr++;
            if (phase != 0 && sdata !== prev_sd) perr++;
            prev_sd = sdata;
            if (phase == 10) begin
                idx = 6'(63 - slot);
                cap[idx] = sdata;
            end
            if (underrun === 1'b1) begin
                urc++;
                if (c == 0) ur0 = 1;
            end
            if (c == 0) begin
                if (v.send) begin
                    s_left = v.l; s_right = v.r; s_valid = 1'b1;
                end else begin
                    s_valid = 1'b0;
                end
            end
            if (pend) begin
                pend = 1'b0;
                if (v.keep) begin
                    s_left  = v.l + 24'd1;
                    s_right = v.r + 24'd1;
                end else begin
                    s_valid = 1'b0;
                end
            end
            if (s_valid && s_ready) begin
                xf++;
                pend = 1'b1;
            end
        end
        check({tag, " sdata"}, cap, frame_word(v.el, v.er));
        check({tag, " underrun"}, 64'(urc * 2 + ur0), 64'(v.eur ? 3 : 0));
        check({tag, " transfers"}, 64'(xf), 64'(v.exf));
        check({tag, " clocks"}, 64'(perr), 64'(0));
    endtask

    initial begin
        int n, early, errs, urs;
        frame_vec_t sv;

        tbl[0]  = mk(0, 1, 0, 24'hABCDEF, 24'h123456, 24'h000000, 24'h000000, 1, 1);
        tbl[1]  = mk(0, 0, 0, 24'h000000, 24'h000000, 24'hABCDEF, 24'h123456, 0, 0);
        tbl[2]  = mk(0, 0, 0, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 1, 0);
        tbl[3]  = mk(0, 1, 0, 24'h800001, 24'h7FFFFE, 24'h000000, 24'h000000, 1, 1);
        tbl[4]  = mk(0, 1, 0, 24'hFFFFFF, 24'h000000, 24'h800001, 24'h7FFFFE, 0, 1);
        tbl[5]  = mk(0, 1, 0, 24'h000001, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 0, 1);
        tbl[6]  = mk(0, 0, 0, 24'h000000, 24'h000000, 24'h000001, 24'hFFFFFF, 0, 0);
        tbl[7]  = mk(0, 0, 0, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 1, 0);
        tbl[8]  = mk(1, 0, 0, 24'h5A5A5A, 24'hA5A5A5, 24'h000000, 24'h000000, 1, 0);
        tbl[9]  = mk(0, 0, 0, 24'h000000, 24'h000000, 24'h5A5A5A, 24'hA5A5A5, 0, 0);
        tbl[10] = mk(0, 0, 0, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 1, 0);

        rst = 1'b1; pll_locked = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
        repeat (3) tick();
        check("reset outputs", 64'({bclk, lrclk, sdata, s_ready, underrun, running}), 64'(0));
        rst = 1'b0;
        repeat (20) tick();
        check("idle without lock", 64'({s_ready, running}), 64'(0));

        // Lock qualification with a one-cycle dropout.
        early = 0;
        pll_locked = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (running !== 1'b0) early++;
        end
        pll_locked = 1'b0;
        tick();
        if (running !== 1'b0) early++;
        pll_locked = 1'b1;
        wait_running(n);
        check("running before requal", 64'(early), 64'(0));
        check("lock latency", 64'(n), 64'(259));
        first_frame("start");

        for (int i = 0; i < 11; i++) run_frame(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 9; i++) begin
            sv = mk(0, (i < 8), 1, 24'h100000 + 24'(i), 24'h200000 + 24'(i),
                    (i == 0) ? 24'h000000 : 24'h100000 + 24'(i - 1),
                    (i == 0) ? 24'h000000 : 24'h200000 + 24'(i - 1),
                    (i == 0), (i < 8) ? 1 : 0);
            run_frame(sv, $sformatf("stream%0d", i));
        end

        // Lock loss in the left slot with a pair waiting in the holding buffer.
        run_frame(mk(0, 1, 0, 24'hFFFFFF, 24'h000000, 24'h000000, 24'h000000, 1, 1), "ll prep");
        for (int c = 0; c < 300; c++) begin
            tick();
            if (c == 0) begin
                check("ll ready", 64'(s_ready), 64'(1));
                s_left = 24'h0F0F0F; s_right = 24'hF0F0F0; s_valid = 1'b1;
            end
            if (c == 1) s_valid = 1'b0;
            if (c == 290) check("ll data before loss", 64'(sdata), 64'(1));
        end
        pll_locked = 1'b0;
        urs = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (underrun !== 1'b0) urs++;
        end
        check("ll outputs", 64'({running, bclk, lrclk, sdata, s_ready}), 64'(0));
        errs = 0;
        for (int k = 0; k < 1300; k++) begin
            tick();
            if ({running, bclk, lrclk, sdata, s_ready, underrun} !== 6'b0) errs++;
        end
        check("ll underrun", 64'(urs), 64'(0));
        check("ll quiet", 64'(errs), 64'(0));
        pll_locked = 1'b1;
        wait_running(n);
        check("relock latency", 64'(n), 64'(259));
        first_frame("relock");
        run_frame(mk(0, 0, 0, 24'h0, 24'h0, 24'h0, 24'h0, 1, 0), "relock discard");

        // Reset while the holding buffer is full.
        for (int c = 0; c <= 100; c++) begin
            tick();
            if (c == 0) begin
                check("rst ready", 64'(s_ready), 64'(1));
                s_left = 24'h13579B; s_right = 24'h2468AC; s_valid = 1'b1;
            end
            if (c == 1) begin
                s_valid = 1'b0;
                check("rst buffer full", 64'(s_ready), 64'(0));
            end
        end
        rst = 1'b1;
        tick();
        check("rst outputs", 64'({bclk, lrclk, sdata, s_ready, underrun, running}), 64'(0));
        rst = 1'b0;
        wait_running(n);
        check("rst relock latency", 64'(n), 64'(259));
        first_frame("post rst");
        run_frame(mk(0, 0, 0, 24'h0, 24'h0, 24'h0, 24'h0, 1, 0), "rst discard");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

Audio serial transmitter clocked by the 61.44 MHz output of the audio PLL. Accepts stereo sample pairs over a valid/ready handshake and produces standard I2S signals: BCLK = 3.072 MHz, LRCLK = 48 kHz, 64 BCLK per frame, two 32-bit slots carrying 24-bit MSB-first samples. Operation starts only after the PLL lock indication has been stable, and stops immediately when lock drops.

## Interface
- `BCLK_DIV`, 20: refclk cycles per BCLK period; even, ≥ 4.
- `LOCK_CYCLES`, 256: consecutive cycles `pll_locked` must be high before transmission starts.
- `SAMPLE_WIDTH`, 24: sample bits per slot, ≤ 32.

- `refclk` in 1: 61.44 MHz PLL output clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: PLL lock, asynchronous to `refclk`; synchronized internally with 2 flops.
- `s_valid` in 1: sample pair valid.
- `s_ready` out 1: holding buffer empty and block running.
- `s_left` in `SAMPLE_WIDTH`: left sample, two's complement.
- `s_right` in `SAMPLE_WIDTH`: right sample.
- `bclk` out 1: bit clock.
- `lrclk` out 1: word select; 0 = left, 1 = right.
- `sdata` out 1: serial data.
- `underrun` out 1: one-cycle pulse when a frame starts with no sample pair available.
- `running` out 1: high in RUN state.

## Operation
- States: WAIT_LOCK (reset state) and RUN.
- WAIT_LOCK: lock counter increments while synchronized lock = 1, and clears to 0 when it is 0. After `LOCK_CYCLES` consecutive high cycles, enter RUN next cycle with `div_cnt` = 0, `bit_cnt` = 0, frame register = 0.
- RUN -> WAIT_LOCK on the first cycle synchronized lock = 0. On that transition, clear all counters, holding buffer and frame register, and force outputs to reset values.
- `div_cnt` counts 0..`BCLK_DIV`-1. `bit_cnt` (6 bits) increments when `div_cnt` wraps and wraps from 63 to 0.
- `bclk` = 0 while `div_cnt` < `BCLK_DIV`/2, otherwise 1. `lrclk` = `bit_cnt`[5].
- `sdata` per slot k (`SAMPLE_WIDTH` = 24):
  - k = 1..24: left[24-k].
  - k = 33..56: right[56-k].
  - All other slots: 0. This gives the one-BCLK I2S delay and zero padding.
- `sdata` changes only on a `bclk` falling edge.
- Handshake:
  - Transfer occurs when `s_valid` && `s_ready`. The pair is captured into the holding buffer and `s_ready` goes low the next cycle.
  - `s_ready` = RUN && holding buffer empty.
  - Data must remain stable while `s_valid` is high and `s_ready` is low.
- Frame boundary is the cycle with `bit_cnt` = 63 and `div_cnt` = `BCLK_DIV`-1.
  - If the holding buffer is full, move it to the frame register and mark the buffer empty.
  - If it is empty, load zeros into the frame register and pulse `underrun` on the next cycle.
- Simultaneous boundary and handshake with an empty buffer: the accepted pair goes to the holding buffer for the following frame, and the current frame underruns.

## Timing
- Reset values: `bclk`, `lrclk`, `sdata`, `s_ready`, `underrun`, `running` all 0; state WAIT_LOCK; all counters and buffers 0.
- All outputs are registered. Output at RUN cycle n reflects `div_cnt` = n mod `BCLK_DIV`.
- `running` rises on the first RUN cycle, which is `LOCK_CYCLES` + 3 cycles after `pll_locked` rises (2 synchronizer cycles + 1 state register cycle).
- Frame period = 64 × `BCLK_DIV` = 1280 cycles. `lrclk` toggles every 640 cycles. BCLK duty is 50%.
- Sample latency: a pair accepted during frame F appears in frame F+1. First data bit (left MSB) appears `BCLK_DIV` cycles after that frame's `lrclk` falls.
- Throughput: one pair per frame. `s_ready` re-asserts on the cycle after the frame boundary.
- `rst` mid-operation: next cycle is at reset values, regardless of lock.
- Lock loss mid-frame: the partial frame is discarded, with no `underrun` pulse. A full `LOCK_CYCLES` requalification is required before restart.

## Test plan
- Lock qualification:
  - Stimulus: `pll_locked` high 100 cycles, low 1 cycle, then high.
  - Required: `running` rises exactly 256 + 3 cycles after the final rise, with no earlier rise.
- Single frame:
  - Stimulus: in RUN, send L = 0xABCDEF and R = 0x123456.
  - Required: next frame `sdata` slots 1..24 = 0xABCDEF and slots 33..56 = 0x123456, all other slots 0.
  - Required: `bclk` period 20 cycles, `lrclk` period 1280 cycles.
- Underrun:
  - Stimulus: hold `s_valid` = 0 across a frame boundary.
  - Required: `underrun` = 1 for exactly one cycle after the boundary, and the whole frame's `sdata` = 0.
- Back-to-back stream:
  - Stimulus: `s_valid` held high with incrementing samples for 8 frames.
  - Required: one transfer per frame, no underrun, and each frame carries the previous frame's accepted pair.
- Lock loss:
  - Stimulus: drop `pll_locked` mid-left-slot.
  - Required: within 3 cycles `running`, `bclk`, `lrclk`, `sdata`, `s_ready` = 0 and no `underrun` pulse.
  - Required: on relock, restart after requalification with a zero frame.
- Reset mid-transfer:
  - Stimulus: assert `rst` for 1 cycle while the holding buffer is full.
  - Required: all outputs 0 the next cycle, the buffer is discarded, and the lock count restarts.
